// File: rtl/ctrl_pipe_if.sv
// Bundle of decode-side inputs and per-stage control outputs for ctrl_pipe.
// master drives the decode/hazard side; slave is the pipeline itself.
interface ctrl_pipe_if #(
  parameter int CW     = 16,
  parameter int STAGES = 3
);
  logic [CW-1:0]        ctrl_d;
  logic                 valid_d;
  logic                 mc_d;
  logic [STAGES-1:0]    stall;
  logic [STAGES-1:0]    flush;
  logic [STAGES*CW-1:0] ctrl_q;
  logic [STAGES-1:0]    valid_q;
  logic                 accept_d;
  logic                 mc_busy;
  logic [31:0]          retired_cnt;
  logic [31:0]          bubble_cnt;

  modport master (
    output ctrl_d, valid_d, mc_d, stall, flush,
    input  ctrl_q, valid_q, accept_d, mc_busy, retired_cnt, bubble_cnt
  );

  modport slave (
    input  ctrl_d, valid_d, mc_d, stall, flush,
    output ctrl_q, valid_q, accept_d, mc_busy, retired_cnt, bubble_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Control-word pipeline after decode with multi-cycle hold of stage 0; CTRL_PIPE_PERF_EN adds perf counters.
// Latency: one cycle per stage; a multi-cycle op stays in stage 0 for MC_CYCLES cycles.
// Backpressure: stall[k] holds stages 0..k, bubbles fill below the hold; accept_d low while stage 0 is held.
module ctrl_pipe #(
  parameter int CW        = 16,
  parameter int STAGES    = 3,
  parameter int MC_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [7:0] MC_LOAD = 8'(MC_CYCLES - 1);

  state_e            state_q, state_d;
  logic [7:0]        mc_cnt_q, mc_cnt_d;
  logic              mc_busy;
  logic [STAGES-1:0] hold;

  logic [CW-1:0]     stg_ctrl_q [STAGES];
  logic [CW-1:0]     stg_ctrl_d [STAGES];
  logic [STAGES-1:0] stg_vld_q, stg_vld_d;

  // A hold anywhere downstream propagates upstream; stage 0 also waits on the multi-cycle op.
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold[k] = ((bus.stall >> k) != '0) || ((k == 0) && mc_busy);
    end
  end

  assign bus.accept_d = ~hold[0];

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_ctrl_d[k] = stg_ctrl_q[k];
    end
    stg_vld_d = stg_vld_q;

    if (bus.flush[0]) begin
      stg_ctrl_d[0] = '0;
      stg_vld_d[0]  = 1'b0;
    end else if (!hold[0]) begin
      stg_ctrl_d[0] = bus.ctrl_d;
      stg_vld_d[0]  = bus.valid_d;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (bus.flush[k]) begin
        stg_ctrl_d[k] = '0;
        stg_vld_d[k]  = 1'b0;
      end else if (!hold[k]) begin
        if (hold[k-1]) begin
          stg_ctrl_d[k] = '0;
          stg_vld_d[k]  = 1'b0;
        end else begin
          stg_ctrl_d[k] = stg_ctrl_q[k-1];
          stg_vld_d[k]  = stg_vld_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_ctrl_q[k] <= '0;
      end
      stg_vld_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stg_ctrl_q[k] <= stg_ctrl_d[k];
      end
      stg_vld_q <= stg_vld_d;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_out
    assign bus.ctrl_q[g*CW +: CW] = stg_ctrl_q[g];
  end
  assign bus.valid_q = stg_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // The counter runs free of external stall so the op's stage-0 residency is fixed.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!hold[0] && bus.valid_d && bus.mc_d && !bus.flush[0]) begin
          state_d  = BUSY;
          mc_cnt_d = MC_LOAD;
        end
      end
      BUSY: begin
        if (bus.flush[0] || (mc_cnt_q == 8'd1)) begin
          state_d  = IDLE;
          mc_cnt_d = '0;
        end else begin
          mc_cnt_d = mc_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        mc_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mc_busy = (state_q == BUSY);
  end

  assign bus.mc_busy = mc_busy;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] retired_q, bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      bubble_q  <= '0;
    end else begin
      if (stg_vld_q[STAGES-1] && !bus.stall[STAGES-1] && !bus.flush[STAGES-1]) begin
        retired_q <= retired_q + 32'd1;
      end
      if (!stg_vld_q[STAGES-1]) begin
        bubble_q <= bubble_q + 32'd1;
      end
    end
  end

  assign bus.retired_cnt = retired_q;
  assign bus.bubble_cnt  = bubble_q;
`else
  assign bus.retired_cnt = '0;
  assign bus.bubble_cnt  = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: directed scenarios plus random traffic against a cycle-indexed reference model.
module tb_ctrl_pipe;
  localparam int CW = 16;
  localparam int S  = 3;
  localparam int MC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_if #(.CW(CW), .STAGES(S)) bus();
  ctrl_pipe #(.CW(CW), .STAGES(S), .MC_CYCLES(MC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stage contents plus the cycle index until which stage 0 is owned by a multi-cycle op.
  logic [CW-1:0] m_ctrl [S];
  logic [S-1:0]  m_vld;
  longint        m_cyc = 0;
  longint        m_busy_end = 0;
  logic [31:0]   m_ret, m_bub;

  function automatic logic m_busy();
    return m_cyc < m_busy_end;
  endfunction

  function automatic logic m_accept();
    return (bus.stall == '0) && !m_busy();
  endfunction

  function automatic logic [S*CW-1:0] m_flat();
    logic [S*CW-1:0] r;
    for (int k = 0; k < S; k++) r[k*CW +: CW] = m_ctrl[k];
    return r;
  endfunction

  task automatic model_step();
    logic [CW-1:0] nc [S];
    logic [S-1:0]  nv;
    logic [S-1:0]  h;
    for (int k = 0; k < S; k++) h[k] = ((bus.stall >> k) != '0) || (k == 0 && m_busy());
    if (rst) begin
      for (int k = 0; k < S; k++) m_ctrl[k] = '0;
      m_vld = '0; m_busy_end = 0; m_ret = '0; m_bub = '0;
      m_cyc++;
      return;
    end
`ifdef CTRL_PIPE_PERF_EN
    if (m_vld[S-1] && !bus.stall[S-1] && !bus.flush[S-1]) m_ret = m_ret + 32'd1;
    if (!m_vld[S-1]) m_bub = m_bub + 32'd1;
`endif
    for (int k = 0; k < S; k++) begin
      if (bus.flush[k])   begin nc[k] = '0; nv[k] = 1'b0; end
      else if (h[k])      begin nc[k] = m_ctrl[k]; nv[k] = m_vld[k]; end
      else if (k == 0)    begin nc[k] = bus.ctrl_d; nv[k] = bus.valid_d; end
      else if (h[k-1])    begin nc[k] = '0; nv[k] = 1'b0; end
      else                begin nc[k] = m_ctrl[k-1]; nv[k] = m_vld[k-1]; end
    end
    if (m_busy()) begin
      if (bus.flush[0]) m_busy_end = 0;
    end else if (!h[0] && bus.valid_d && bus.mc_d && !bus.flush[0]) begin
      m_busy_end = m_cyc + MC;
    end
    for (int k = 0; k < S; k++) m_ctrl[k] = nc[k];
    m_vld = nv;
    m_cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic m,
                       input logic [S-1:0] st, input logic [S-1:0] fl);
    bus.valid_d = v; bus.ctrl_d = c; bus.mc_d = m; bus.stall = st; bus.flush = fl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'hBEEF, 1'b0, '0, '0);
    tick(); tick();
    rst = 1'b0;
    drive(1'b1, 16'h0A0A, 1'b1, '0, '0);
    tick();
    n_checks++; if (bus.mc_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy: got %b want 1", bus.mc_busy); end
    rst = 1'b1;
    drive(1'b1, 16'h1234, 1'b1, 3'b111, 3'b000);
    tick();
    n_checks++; if (bus.valid_q !== 3'b000) begin n_fail++; $display("FAIL rst_valid: got %b want 000", bus.valid_q); end
    n_checks++; if (bus.ctrl_q !== '0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", bus.ctrl_q); end
    n_checks++; if (bus.mc_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.mc_busy); end
    n_checks++; if (bus.retired_cnt !== 32'd0 || bus.bubble_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", bus.retired_cnt, bus.bubble_cnt); end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 3'b000, '0);
    n_checks++; if (bus.accept_d !== 1'b1) begin n_fail++; $display("FAIL rst_accept: got %b want 1", bus.accept_d); end
    drive(1'b0, '0, 1'b0, 3'b100, '0);
    n_checks++; if (bus.accept_d !== 1'b0) begin n_fail++; $display("FAIL rst_accept_stall: got %b want 0", bus.accept_d); end
    drive(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_stream();
    logic [CW-1:0] words [3];
    words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, words[i], 1'b0, '0, '0);
      n_checks++; if (bus.accept_d !== 1'b1) begin n_fail++; $display("FAIL stream_accept%0d: got %b want 1", i, bus.accept_d); end
      tick();
    end
    n_checks++; if (bus.ctrl_q[2*CW +: CW] !== 16'h0011) begin n_fail++; $display("FAIL stream_stage2: got %h want 0011", bus.ctrl_q[2*CW +: CW]); end
    n_checks++; if (bus.valid_q !== 3'b111) begin n_fail++; $display("FAIL stream_valid: got %b want 111", bus.valid_q); end
    n_checks++; if (bus.ctrl_q !== 48'h0011_0022_0033) begin n_fail++; $display("FAIL stream_ctrl: got %h want 001100220033", bus.ctrl_q); end
  endtask

  task automatic test_stall();
    drive(1'b1, 16'h0044, 1'b0, 3'b010, '0);
    n_checks++; if (bus.accept_d !== 1'b0) begin n_fail++; $display("FAIL stall_accept: got %b want 0", bus.accept_d); end
    tick();
    n_checks++; if (bus.valid_q !== 3'b011) begin n_fail++; $display("FAIL stall_valid: got %b want 011", bus.valid_q); end
    n_checks++; if (bus.ctrl_q !== 48'h0000_0022_0033) begin n_fail++; $display("FAIL stall_ctrl: got %h want 000000220033", bus.ctrl_q); end
  endtask

  task automatic test_flush_hold();
    drive(1'b1, 16'h0055, 1'b0, 3'b010, 3'b010);
    tick();
    n_checks++; if (bus.valid_q[1] !== 1'b0 || bus.ctrl_q[CW +: CW] !== 16'h0000) begin
      n_fail++; $display("FAIL flush_hold_s1: got v=%b c=%h want v=0 c=0000", bus.valid_q[1], bus.ctrl_q[CW +: CW]); end
    n_checks++; if (bus.ctrl_q !== 48'h0000_0000_0033 || bus.valid_q !== 3'b001) begin
      n_fail++; $display("FAIL flush_hold_all: got %h/%b want 000000000033/001", bus.ctrl_q, bus.valid_q); end
  endtask

  task automatic test_multicycle();
    int nb, na, nr;
    nb = 0; na = 0; nr = 0;
    drive(1'b1, 16'h00AA, 1'b1, '0, '0);
    n_checks++; if (bus.accept_d !== 1'b1) begin n_fail++; $display("FAIL mc_accept: got %b want 1", bus.accept_d); end
    tick();
    drive(1'b1, 16'h00BB, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      if (bus.mc_busy) nb++;
      if (!bus.accept_d) na++;
      if (bus.valid_q[0] && bus.ctrl_q[CW-1:0] == 16'h00AA) nr++;
      if (i == 4) begin
        n_checks++; if (bus.ctrl_q[CW +: CW] !== 16'h00AA) begin n_fail++; $display("FAIL mc_leave: got %h want 00AA", bus.ctrl_q[CW +: CW]); end
      end
      n_checks++; if (bus.valid_q !== m_vld || bus.ctrl_q !== m_flat()) begin
        n_fail++; $display("FAIL mc_model%0d: got %h/%b want %h/%b", i, bus.ctrl_q, bus.valid_q, m_flat(), m_vld); end
      tick();
    end
    n_checks++; if (nb != MC - 1) begin n_fail++; $display("FAIL mc_busy_cycles: got %0d want %0d", nb, MC - 1); end
    n_checks++; if (na != MC - 1) begin n_fail++; $display("FAIL mc_accept_low: got %0d want %0d", na, MC - 1); end
    n_checks++; if (nr != MC) begin n_fail++; $display("FAIL mc_residency: got %0d want %0d", nr, MC); end
  endtask

  task automatic test_abort();
    drive(1'b1, 16'h00CC, 1'b1, '0, '0);
    tick();
    drive(1'b1, 16'h00DD, 1'b0, '0, '0);
    n_checks++; if (bus.mc_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy1: got %b want 1", bus.mc_busy); end
    tick();
    n_checks++; if (bus.mc_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy2: got %b want 1", bus.mc_busy); end
    drive(1'b1, 16'h00DD, 1'b0, '0, 3'b001);
    tick();
    drive(1'b1, 16'h00DD, 1'b0, '0, '0);
    n_checks++; if (bus.mc_busy !== 1'b0 || bus.accept_d !== 1'b1) begin
      n_fail++; $display("FAIL abort_release: got busy=%b acc=%b want 0/1", bus.mc_busy, bus.accept_d); end
    n_checks++; if (bus.valid_q[0] !== 1'b0) begin n_fail++; $display("FAIL abort_s0: got %b want 0", bus.valid_q[0]); end
  endtask

  task automatic test_perf();
    logic [6:0] pat;
    logic [31:0] want_r, want_b;
    pat = 7'b1101101;
`ifdef CTRL_PIPE_PERF_EN
    want_r = 32'd5; want_b = 32'd5;
`else
    want_r = 32'd0; want_b = 32'd0;
`endif
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(pat[i], pat[i] ? CW'(16'h0100 + i) : '0, 1'b0, '0, '0);
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus.retired_cnt !== want_r) begin n_fail++; $display("FAIL perf_retired: got %0d want %0d", bus.retired_cnt, want_r); end
    n_checks++; if (bus.bubble_cnt !== want_b) begin n_fail++; $display("FAIL perf_bubble: got %0d want %0d", bus.bubble_cnt, want_b); end
  endtask

  task automatic test_random();
    logic v;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 3) != 0);
      drive(v, v ? CW'($urandom) : '0, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0) ? S'($urandom) : '0,
            ($urandom_range(0, 9) == 0) ? S'($urandom) : '0);
      n_checks++; if (bus.accept_d !== m_accept()) begin n_fail++; $display("FAIL rnd_accept@%0d: got %b want %b", i, bus.accept_d, m_accept()); end
      tick();
      n_checks++; if (bus.valid_q !== m_vld) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, bus.valid_q, m_vld); end
      n_checks++; if (bus.ctrl_q !== m_flat()) begin n_fail++; $display("FAIL rnd_ctrl@%0d: got %h want %h", i, bus.ctrl_q, m_flat()); end
      n_checks++; if (bus.mc_busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", i, bus.mc_busy, m_busy()); end
      n_checks++; if (bus.retired_cnt !== m_ret || bus.bubble_cnt !== m_bub) begin
        n_fail++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", i, bus.retired_cnt, bus.bubble_cnt, m_ret, m_bub); end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < S; k++) m_ctrl[k] = '0;
    m_vld = '0; m_ret = '0; m_bub = '0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_hold();
    test_multicycle();
    test_abort();
    test_perf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL accept parameter CW, default 16, as the width of one control word.
REQ-002 The block SHALL accept parameter STAGES, default 3 (E, M, W), legal range 2..5, as the number of control pipeline stages after decode.
REQ-003 The block SHALL accept parameter MC_CYCLES, default 32, legal range 2..255, as the stage-0 residency of a multi-cycle op.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port ctrl_d, input, CW bits: the decoded control word from decode.
REQ-007 The block SHALL have port valid_d, input, 1 bit: ctrl_d is a real instruction.
REQ-008 The block SHALL have port mc_d, input, 1 bit: the decoded op is multi-cycle (mult/div class).
REQ-009 The block SHALL have port stall, input, STAGES bits: bit k is an external hold request for stage k.
REQ-010 The block SHALL have port flush, input, STAGES bits: bit k clears stage k.
REQ-011 The block SHALL have port ctrl_q, output, STAGES*CW bits: stage k occupies bits [k*CW +: CW].
REQ-012 The block SHALL have port valid_q, output, STAGES bits: per-stage valid.
REQ-013 The block SHALL have port accept_d, output, 1 bit: stage 0 loads ctrl_d this cycle.
REQ-014 The block SHALL have port mc_busy, output, 1 bit: a multi-cycle op holds stage 0.
REQ-015 The block SHALL have port retired_cnt, output, 32 bits: retired-instruction count.
REQ-016 The block SHALL have port bubble_cnt, output, 32 bits: last-stage bubble count.

Function
REQ-017 The block SHALL compute hold[k] = OR of stall[k..STAGES-1], additionally ORed with mc_busy for k=0.
REQ-018 The block SHALL drive accept_d = ~hold[0] combinationally.
REQ-019 When ~hold[0], stage 0 SHALL load ctrl_d and valid_d on the next edge.
REQ-020 For k>0 with ~hold[k] and ~hold[k-1], stage k SHALL load stage k-1.
REQ-021 For k>0 with ~hold[k] and hold[k-1], stage k SHALL load a bubble (ctrl 0, valid 0).
REQ-022 When hold[k], stage k SHALL retain its contents.
REQ-023 flush[k] SHALL override hold and load: stage k becomes ctrl 0, valid 0 on the next edge.
REQ-024 Flushed or bubbled stages SHALL carry an all-zero ctrl word, so no write enables are asserted.
REQ-025 The FSM SHALL have states IDLE and BUSY, plus an 8-bit down-counter mc_cnt.
REQ-026 IDLE to BUSY SHALL occur when accept_d & valid_d & mc_d & ~flush[0], loading mc_cnt = MC_CYCLES-1.
REQ-027 In BUSY, mc_cnt SHALL decrement every cycle regardless of external stall.
REQ-028 In BUSY, the FSM SHALL go to IDLE on the edge where mc_cnt == 1.
REQ-029 Together, REQ-026 to REQ-028 SHALL give mc_busy high for exactly MC_CYCLES-1 cycles and stage-0 residency of MC_CYCLES cycles when not otherwise stalled.
REQ-030 flush[0] in BUSY SHALL force IDLE and mc_cnt 0 on the next edge.
REQ-031 Simultaneous abort via flush[0] and a new accept SHALL NOT be possible, since accept_d is 0 while busy.
REQ-032 mc_busy SHALL equal (state == BUSY) and be registered-state derived.

Reset
REQ-033 With rst high at an edge, all valid_q bits SHALL be 0, all ctrl_q bits 0, state IDLE, mc_cnt 0 and both counters 0.
REQ-034 rst SHALL take priority over stall, flush and the FSM, including mid-BUSY.
REQ-035 In the cycle after reset, accept_d SHALL be 1 unless stall is nonzero.

Configuration
REQ-036 Macro CTRL_PIPE_PERF_EN defined SHALL mean retired_cnt increments when valid_q[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1].
REQ-037 Macro CTRL_PIPE_PERF_EN defined SHALL mean bubble_cnt increments when ~valid_q[STAGES-1].
REQ-038 Both counters SHALL wrap modulo 2^32.
REQ-039 Macro CTRL_PIPE_PERF_EN undefined SHALL mean both counter ports are present, tied to 0, with no counter flops.

Verification
REQ-040 Test stream: with STAGES=3 and ctrl_d = 0x0011, 0x0022, 0x0033 on consecutive cycles, all valid, no stall, ctrl_q stage 2 SHALL show 0x0011 three cycles after its accept, with valid_q = 3'b111 at steady state.
REQ-041 Test stall: with stall = 3'b010 for 1 cycle, stage 0 and stage 1 SHALL hold, stage 2 SHALL get a bubble (valid_q[2]=0), and accept_d = 0 for that cycle.
REQ-042 Test flush vs hold: with flush[1]=1 and stall[1]=1 in the same cycle, stage 1 SHALL become valid 0 and ctrl 0x0000.
REQ-043 Test multi-cycle op: with MC_CYCLES=4, a valid mc_d op SHALL give mc_busy high for 3 cycles, accept_d low for 3 cycles, and the op leaving stage 0 after 4 cycles.
REQ-044 Test abort: flush[0] on the 2nd BUSY cycle SHALL give mc_busy 0 and accept_d 1 on the next cycle.
REQ-045 Test perf: with CTRL_PIPE_PERF_EN, 5 valid ops and 2 bubbles reaching the last stage SHALL give retired_cnt = 5 and bubble_cnt ≥ 2 with exact cycle count checked; without the macro, both SHALL read 0.
